// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// ----------------
// Owns the single read/write port of the main RAM. After reset it first fills
// every location with FILL. It then shares the port between two requesters:
//   - the machine bus (CPU/ULA), which always wins;
//   - a tape-loader write stream, buffered in a small FIFO and drained into
//     idle bus cycles.
// Every RAM-side output is registered.
//
// Ports
//   clk            system clock
//   reset_n        synchronous active-low reset
//   cpu_ad/_d      machine bus address / write data
//   cpu_cs/_we     machine bus request (every cycle it is high) / write enable
//   cpu_q          read data back to the machine bus (RAM data, FILL while clearing)
//   tape_addr/dout loader write address / data
//   tape_wr        loader write strobe, accepted when tape_ready=1
//   tape_last      tags the accepted write as the final byte of the image
//   tape_ready     FIFO has room and the arbiter is in RUN
//   tape_complete  one-cycle pulse when the tagged byte is written to RAM
//   tape_overflow  sticky, set by a tape_wr that arrives while tape_ready=0
//   clear_busy     high while the power-on clear runs
//   ram_a/d/ce/we  registered RAM port
//   ram_q          RAM read data (one-cycle latency inside the RAM)

module ram_port_arbiter #(
  parameter int         AW         = 16,
  parameter logic [7:0] FILL       = 8'hFF,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] cpu_ad,
  input  logic [7:0]    cpu_d,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  output logic [7:0]    cpu_q,
  input  logic [AW-1:0] tape_addr,
  input  logic [7:0]    tape_dout,
  input  logic          tape_wr,
  input  logic          tape_last,
  output logic          tape_ready,
  output logic          tape_complete,
  output logic          tape_overflow,
  output logic          clear_busy,
  output logic [AW-1:0] ram_a,
  output logic [7:0]    ram_d,
  output logic          ram_ce,
  output logic          ram_we,
  input  logic [7:0]    ram_q
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t        state_q;
  logic [AW-1:0] clearCnt_q;

  logic [AW-1:0] ramA_q;
  logic [7:0]    ramD_q;
  logic          ramCe_q;
  logic          ramWe_q;
  logic          complete_q;
  logic          overflow_q;
  logic          overflow_d;

  logic [AW-1:0] fifoAddr_q [FIFO_DEPTH];
  logic [7:0]    fifoData_q [FIFO_DEPTH];
  logic          fifoLast_q [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;

  logic push;
  logic pop;

  // Room is judged from the registered count only, so a pop in the same cycle
  // never lets a push into a full FIFO.
  assign tape_ready = (state_q == RUN) && (count_q < CW'(FIFO_DEPTH));
  assign push       = tape_wr && tape_ready;
  // The FIFO only gets the port in cycles the bus leaves idle.
  assign pop        = (state_q == RUN) && !cpu_cs && (count_q != '0);

  // FIFO pointer/count and sticky overflow next-state.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (tape_wr & ~tape_ready);
    if (push) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // FIFO storage. Only the last-tag bits are reset. Address and data are
  // always qualified by the count, so they need no reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifoLast_q[i] <= 1'b0;
      end
    end else if (push) begin
      fifoAddr_q[wrPtr_q] <= tape_addr;
      fifoData_q[wrPtr_q] <= tape_dout;
      fifoLast_q[wrPtr_q] <= tape_last;
    end
  end

  // Arbiter FSM and registered RAM port. CLEAR walks every address once,
  // writing FILL. RUN gives the port to the bus first, then to the FIFO head.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      clearCnt_q <= '0;
      ramA_q     <= '0;
      ramD_q     <= '0;
      ramCe_q    <= 1'b0;
      ramWe_q    <= 1'b0;
      complete_q <= 1'b0;
      overflow_q <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
    end else begin
      overflow_q <= overflow_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      complete_q <= 1'b0;
      unique case (state_q)
        CLEAR: begin
          ramCe_q    <= 1'b1;
          ramWe_q    <= 1'b1;
          ramA_q     <= clearCnt_q;
          ramD_q     <= FILL;
          clearCnt_q <= clearCnt_q + 1'b1;
          // The final address is being driven now, so leave CLEAR with it.
          if (clearCnt_q == '1) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (cpu_cs) begin
            ramCe_q <= 1'b1;
            ramWe_q <= cpu_we;
            ramA_q  <= cpu_ad;
            ramD_q  <= cpu_d;
          end else if (pop) begin
            ramCe_q    <= 1'b1;
            ramWe_q    <= 1'b1;
            ramA_q     <= fifoAddr_q[rdPtr_q];
            ramD_q     <= fifoData_q[rdPtr_q];
            complete_q <= fifoLast_q[rdPtr_q];
          end else begin
            // ram_a/ram_d keep their last values while the port is idle.
            ramCe_q <= 1'b0;
            ramWe_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ram_a         = ramA_q;
  assign ram_d         = ramD_q;
  assign ram_ce        = ramCe_q;
  assign ram_we        = ramWe_q;
  assign tape_complete = complete_q;
  assign tape_overflow = overflow_q;
  assign clear_busy    = (state_q == CLEAR);
  // While clearing, RAM contents are in flux, so the bus sees the fill value.
  assign cpu_q         = (state_q == CLEAR) ? FILL : ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// -------------------
// Directed bench for ram_port_arbiter. A behavioural 64 KB RAM with one-cycle
// registered reads sits on the RAM port. Expected values are hand-computed.

module tb_ram_port_arbiter;

  logic        clk;
  logic        resetN;
  logic [15:0] cpuAd;
  logic [7:0]  cpuD;
  logic        cpuCs;
  logic        cpuWe;
  logic [7:0]  cpuQ;
  logic [15:0] tapeAddr;
  logic [7:0]  tapeDout;
  logic        tapeWr;
  logic        tapeLast;
  logic        tapeReady;
  logic        tapeComplete;
  logic        tapeOverflow;
  logic        clearBusy;
  logic [15:0] ramA;
  logic [7:0]  ramD;
  logic        ramCe;
  logic        ramWe;
  logic [7:0]  ramQ;

  logic [7:0]  mem [65536];

  int total = 0;
  int bad   = 0;

  ram_port_arbiter #(
    .AW(16),
    .FILL(8'hFF),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset_n(resetN),
    .cpu_ad(cpuAd),
    .cpu_d(cpuD),
    .cpu_cs(cpuCs),
    .cpu_we(cpuWe),
    .cpu_q(cpuQ),
    .tape_addr(tapeAddr),
    .tape_dout(tapeDout),
    .tape_wr(tapeWr),
    .tape_last(tapeLast),
    .tape_ready(tapeReady),
    .tape_complete(tapeComplete),
    .tape_overflow(tapeOverflow),
    .clear_busy(clearBusy),
    .ram_a(ramA),
    .ram_d(ramD),
    .ram_ce(ramCe),
    .ram_we(ramWe),
    .ram_q(ramQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: writes commit at the edge, reads register data at the edge.
  always @(posedge clk) begin
    if (ramCe) begin
      if (ramWe) begin
        mem[ramA] <= ramD;
      end else begin
        ramQ <= mem[ramA];
      end
    end
  end

  // Hard stop if the run somehow stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock, then settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cs, input logic we, input logic [15:0] ad,
                               input logic [7:0] d, input logic twr,
                               input logic [15:0] taddr, input logic [7:0] tdout,
                               input logic tlast);
    cpuCs    = cs;
    cpuWe    = we;
    cpuAd    = ad;
    cpuD     = d;
    tapeWr   = twr;
    tapeAddr = taddr;
    tapeDout = tdout;
    tapeLast = tlast;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Bus read that is not pipelined: issue, idle one cycle, then check cpu_q.
  task automatic cpuRead(input string tag, input logic [15:0] ad, input logic [7:0] exp);
    applyStimulus(1'b1, 1'b0, ad, 8'h00, 1'b0, 16'h0, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, ad, 8'h00, 1'b0, 16'h0, 8'h00, 1'b0);
    tick();
    checkOutput(tag, {24'h0, cpuQ}, {24'h0, exp});
  endtask

  initial begin
    int clearErr;
    resetN = 1'b0;
    ramQ   = 8'h00;
    applyStimulus(1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 16'h0, 8'h00, 1'b0);
    #1;
    repeat (3) tick();

    // Reset state.
    checkOutput("rst_busy",     {31'h0, clearBusy},    32'h1);
    checkOutput("rst_ready",    {31'h0, tapeReady},    32'h0);
    checkOutput("rst_ce",       {31'h0, ramCe},        32'h0);
    checkOutput("rst_we",       {31'h0, ramWe},        32'h0);
    checkOutput("rst_a",        {16'h0, ramA},         32'h0);
    checkOutput("rst_d",        {24'h0, ramD},         32'h0);
    checkOutput("rst_complete", {31'h0, tapeComplete}, 32'h0);
    checkOutput("rst_overflow", {31'h0, tapeOverflow}, 32'h0);
    checkOutput("rst_cpuq",     {24'h0, cpuQ},         32'hFF);

    // Clear sweep. A bus write is held requested throughout and must be ignored.
    applyStimulus(1'b1, 1'b1, 16'hABCD, 8'h00, 1'b0, 16'h0, 8'h00, 1'b0);
    resetN   = 1'b1;
    clearErr = 0;
    for (int i = 0; i < 65536; i++) begin
      tick();
      if (ramCe !== 1'b1 || ramWe !== 1'b1 || ramA !== 16'(i) || ramD !== 8'hFF)
        clearErr++;
      if (clearBusy !== (i != 65535))
        clearErr++;
      if (i < 65535 && (tapeReady !== 1'b0 || cpuQ !== 8'hFF))
        clearErr++;
      if (i == 65535)
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 16'h0, 8'h00, 1'b0);
    end
    checkOutput("clear_sweep_errors", 32'(clearErr), 32'h0);
    checkOutput("run_busy",  {31'h0, clearBusy}, 32'h0);
    checkOutput("run_ready", {31'h0, tapeReady}, 32'h1);

    // Bus read of a cleared location. Data arrives two cycles after the request.
    applyStimulus(1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 16'h0, 8'h00, 1'b0);
    tick();
    checkOutput("rd1234_ce", {31'h0, ramCe}, 32'h1);
    checkOutput("rd1234_we", {31'h0, ramWe}, 32'h0);
    checkOutput("rd1234_a",  {16'h0, ramA},  32'h1234);
    applyStimulus(1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 16'h0, 8'h00, 1'b0);
    tick();
    checkOutput("rd1234_q",       {24'h0, cpuQ}, 32'hFF);
    checkOutput("idle_ce",        {31'h0, ramCe}, 32'h0);
    checkOutput("idle_a_hold",    {16'h0, ramA},  32'h1234);

    // Bus write then read-back.
    applyStimulus(1'b1, 1'b1, 16'h0400, 8'h5A, 1'b0, 16'h0, 8'h00, 1'b0);
    tick();
    checkOutput("wr0400_we", {31'h0, ramWe}, 32'h1);
    checkOutput("wr0400_a",  {16'h0, ramA},  32'h0400);
    checkOutput("wr0400_d",  {24'h0, ramD},  32'h5A);
    applyStimulus(1'b1, 1'b0, 16'h0400, 8'h00, 1'b0, 16'h0, 8'h00, 1'b0);
    tick();
    checkOutput("rd0400_we", {31'h0, ramWe}, 32'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 16'h0, 8'h00, 1'b0);
    tick();
    checkOutput("rd0400_q", {24'h0, cpuQ}, 32'h5A);

    // Three tape writes with the bus idle. They drain back-to-back, and the last one pulses.
    applyStimulus(1'b0, 1'b0, 16'h0, 8'h00, 1'b1, 16'h0501, 8'h11, 1'b0);
    tick();
    checkOutput("t3_first_ce", {31'h0, ramCe}, 32'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 8'h00, 1'b1, 16'h0502, 8'h22, 1'b0);
    tick();
    checkOutput("t3_w1_a", {16'h0, ramA}, 32'h0501);
    checkOutput("t3_w1_d", {24'h0, ramD}, 32'h11);
    checkOutput("t3_w1_complete", {31'h0, tapeComplete}, 32'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 8'h00, 1'b1, 16'h0503, 8'h33, 1'b1);
    tick();
    checkOutput("t3_w2_a", {16'h0, ramA}, 32'h0502);
    checkOutput("t3_w2_d", {24'h0, ramD}, 32'h22);
    applyStimulus(1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 16'h0, 8'h00, 1'b0);
    tick();
    checkOutput("t3_w3_a",  {16'h0, ramA},  32'h0503);
    checkOutput("t3_w3_d",  {24'h0, ramD},  32'h33);
    checkOutput("t3_w3_we", {31'h0, ramWe}, 32'h1);
    checkOutput("t3_w3_complete", {31'h0, tapeComplete}, 32'h1);
    tick();
    checkOutput("t3_done_ce",       {31'h0, ramCe},        32'h0);
    checkOutput("t3_done_complete", {31'h0, tapeComplete}, 32'h0);
    cpuRead("t3_rb0501", 16'h0501, 8'h11);
    cpuRead("t3_rb0502", 16'h0502, 8'h22);
    cpuRead("t3_rb0503", 16'h0503, 8'h33);

    // FIFO fill while the bus holds the port: four writes accepted, the fifth overflows.
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t4_ready%0d", i), {31'h0, tapeReady}, 32'h1);
      applyStimulus(1'b1, 1'b0, 16'h0, 8'h00, 1'b1, 16'h0601 + 16'(i), 8'hA1 + 8'(i), 1'b0);
      tick();
      checkOutput($sformatf("t4_busy_we%0d", i), {31'h0, ramWe}, 32'h0);
    end
    checkOutput("t4_full_ready",  {31'h0, tapeReady},    32'h0);
    checkOutput("t4_pre_overflow", {31'h0, tapeOverflow}, 32'h0);
    applyStimulus(1'b1, 1'b0, 16'h0, 8'h00, 1'b1, 16'h0605, 8'hA5, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 8'h00, 1'b0, 16'h0, 8'h00, 1'b0);
    checkOutput("t4_overflow", {31'h1, tapeOverflow}, 32'hFFFF_FFFF & {31'h1, 1'b1});
    checkOutput("t4_5th_we",   {31'h0, ramWe},        32'h0);
    tick();
    checkOutput("t4_hold_we",  {31'h0, ramWe},        32'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 16'h0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("t4_drain_we%0d", i), {31'h0, ramWe}, 32'h1);
      checkOutput($sformatf("t4_drain_a%0d", i),  {16'h0, ramA},  32'h0601 + 32'(i));
      checkOutput($sformatf("t4_drain_d%0d", i),  {24'h0, ramD},  32'hA1 + 32'(i));
    end
    tick();
    checkOutput("t4_empty_ce",    {31'h0, ramCe},        32'h0);
    checkOutput("t4_no_complete", {31'h0, tapeComplete}, 32'h0);

    // Full FIFO with the bus alternating. Tape writes only take the idle slots.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0, 8'h00, 1'b1, 16'h0701 + 16'(i), 8'hB1 + 8'(i), 1'b0);
      tick();
    end
    for (int j = 0; j < 8; j++) begin
      applyStimulus(j % 2 == 0, 1'b1, 16'h0800 + 16'(j), 8'hC0 + 8'(j), 1'b0, 16'h0, 8'h00, 1'b0);
      tick();
      checkOutput($sformatf("t5_we%0d", j), {31'h0, ramWe}, 32'h1);
      if (j % 2 == 0) begin
        checkOutput($sformatf("t5_cpu_a%0d", j), {16'h0, ramA}, 32'h0800 + 32'(j));
        checkOutput($sformatf("t5_cpu_d%0d", j), {24'h0, ramD}, 32'hC0 + 32'(j));
      end else begin
        checkOutput($sformatf("t5_tape_a%0d", j), {16'h0, ramA}, 32'h0701 + 32'(j / 2));
        checkOutput($sformatf("t5_tape_d%0d", j), {24'h0, ramD}, 32'hB1 + 32'(j / 2));
      end
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 16'h0, 8'h00, 1'b0);
    tick();
    checkOutput("t5_empty_ce", {31'h0, ramCe}, 32'h0);

    // Reset mid-run with two entries queued. The queue is dropped and the clear restarts at 0.
    applyStimulus(1'b1, 1'b0, 16'h0, 8'h00, 1'b1, 16'h0901, 8'hD1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 8'h00, 1'b1, 16'h0902, 8'hD2, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 16'h0, 8'h00, 1'b0);
    resetN = 1'b0;
    tick();
    checkOutput("t6_rst_busy",     {31'h0, clearBusy},    32'h1);
    checkOutput("t6_rst_ce",       {31'h0, ramCe},        32'h0);
    checkOutput("t6_rst_a",        {16'h0, ramA},         32'h0);
    checkOutput("t6_rst_overflow", {31'h0, tapeOverflow}, 32'h0);
    checkOutput("t6_rst_ready",    {31'h0, tapeReady},    32'h0);
    resetN = 1'b1;
    tick();
    checkOutput("t6_clr0_a",        {16'h0, ramA},         32'h0);
    checkOutput("t6_clr0_d",        {24'h0, ramD},         32'hFF);
    checkOutput("t6_clr0_we",       {31'h0, ramWe},        32'h1);
    checkOutput("t6_clr0_complete", {31'h0, tapeComplete}, 32'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 8'h00, 1'b1, 16'h0A00, 8'hEE, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 8'h00, 1'b0, 16'h0, 8'h00, 1'b0);
    checkOutput("t6_clr1_a",          {16'h0, ramA},         32'h1);
    checkOutput("t6_clear_overflow",  {31'h0, tapeOverflow}, 32'h1);
    tick();
    checkOutput("t6_clr2_a",        {16'h0, ramA},         32'h2);
    checkOutput("t6_clr2_complete", {31'h0, tapeComplete}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Owns the single write/read port of the 64 KB main RAM `dpram`.
- Sequences a power-on clear of the whole RAM, then shares the port between two requesters:
  - the machine-side bus (CPU/ULA), which always wins;
  - a tape-loader write stream, buffered in a small FIFO and drained into idle bus cycles.
- All RAM-side signals are registered, matching the registered RAM interface of the top level.

Parameters:
- AW, 16, RAM address width; clear covers 2^AW locations.
- FILL, 8'hFF, byte written to every location during clear.
- FIFO_DEPTH, 4, tape write FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock (48 MHz domain).
- reset_n  in  1  synchronous, active-low reset.
- cpu_ad  in  AW  machine bus address.
- cpu_d  in  8  machine bus write data.
- cpu_cs  in  1  machine bus access request (every cycle it is high).
- cpu_we  in  1  machine bus write enable, qualified by cpu_cs.
- cpu_q  out  8  read data returned to the machine bus.
- tape_addr  in  AW  loader write address.
- tape_dout  in  8  loader write data.
- tape_wr  in  1  loader write strobe; accepted only when tape_ready=1.
- tape_last  in  1  marks the accepted write as the final byte of the image.
- tape_ready  out  1  FIFO not full.
- tape_complete  out  1  one-cycle pulse when the tape_last byte reaches RAM.
- tape_overflow  out  1  sticky; set when tape_wr arrives while tape_ready=0.
- clear_busy  out  1  high while the clear sequence runs.
- ram_a  out  AW  RAM address (registered).
- ram_d  out  8  RAM write data (registered).
- ram_ce  out  1  RAM chip enable (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_q  in  8  RAM read data (RAM registers it internally; one-cycle read latency).

Behaviour:

Reset (reset_n=0 sampled at a clk edge):
- state=CLEAR, clear counter=0.
- FIFO empty; last-tag cleared.
- ram_ce=0, ram_we=0, ram_a=0, ram_d=0.
- tape_complete=0, tape_overflow=0.
- clear_busy=1, tape_ready=0.
- Reset mid-clear or mid-run restarts the clear from address 0 and discards FIFO contents.

CLEAR state (first cycle after reset_n=1):
- Each cycle drive ram_ce=1, ram_we=1, ram_a=counter, ram_d=FILL; counter increments.
- After address 2^AW-1 has been driven, go to RUN on the next cycle and drop clear_busy the same cycle.
- Clear takes exactly 2^AW cycles: 65536 for AW=16.
- cpu_cs is ignored and cpu_q reads FILL.
- tape_ready=0; tape_wr sets tape_overflow.

RUN state, port grant decided per cycle from the current inputs, result registered onto the RAM port next edge:
- cpu_cs=1 → grant CPU:
  - ram_ce=1, ram_we=cpu_we, ram_a=cpu_ad, ram_d=cpu_d.
  - The CPU is never stalled.
- cpu_cs=0 and FIFO non-empty → pop the head entry:
  - ram_ce=1, ram_we=1, ram_a/ram_d from the entry.
- Otherwise → ram_ce=0, ram_we=0; ram_a and ram_d hold their previous values.
- cpu_q = ram_q (combinational pass-through).
- Read data for a cpu_cs read issued in cycle N is valid on cpu_q in cycle N+2.

FIFO:
- tape_ready = (count < FIFO_DEPTH) and state=RUN, computed from the registered count.
- Push when tape_wr & tape_ready. A pop in the same cycle does not make room for that cycle's push.
- Simultaneous push and pop: count unchanged, order preserved.
- Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- tape_last is stored as a per-entry tag bit.

Tape completion:
- tape_complete pulses high for exactly one cycle, in the same cycle the tagged entry appears on the RAM port (ram_we=1).
- A second tape_last before the first has drained produces a second pulse, in order.

Overflow:
- tape_wr while tape_ready=0 drops the data and sets tape_overflow.
- tape_overflow clears only on reset.

Test Plan:
1. Release reset → clear_busy stays high for 65536 cycles. ram_we=1 with ram_a running 0000..FFFF and ram_d=FF. Then RUN; a CPU read of 0x1234 returns FF on cpu_q two cycles later.
2. CPU write 0x0400←5A, then read 0x0400 → ram_we/ram_a/ram_d registered one cycle after cpu_cs; cpu_q=5A on N+2.
3. cpu_cs held low; push 3 tape writes (0x0501←11, 0x0502←22, 0x0503←33 with tape_last) → RAM writes in order on consecutive cycles. tape_complete pulses with the 0x0503 write; memory reads back 11/22/33.
4. cpu_cs held high continuously; push 5 tape writes → first 4 accepted, tape_ready=0, 5th sets tape_overflow. No tape write reaches RAM until cpu_cs drops, then 4 writes drain in FIFO order.
5. Alternate cpu_cs 1/0 each cycle with a full FIFO → tape writes occupy only the cpu_cs=0 slots. Every CPU access is issued unchanged one cycle later.
6. Assert reset_n=0 with 2 entries queued, mid-RUN → FIFO discarded, no tape_complete, clear restarts at address 0, tape_overflow cleared.
